// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX interrupt controller.
// Holds the trap FSM encoding and the vector address helper.
package dlx_pkg;

  localparam int DLX_WORD = 32;
  localparam logic [DLX_WORD-1:0] DEF_VEC_BASE = 32'h0000_0100;
  localparam int unsigned DEF_VEC_SHIFT = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_INSVC  = 3'd4
  } state_t;

  // id is zero-extended before the shift; the sum wraps at 2^32
  function automatic logic [DLX_WORD-1:0] vec_addr(
    input logic [DLX_WORD-1:0] base,
    input logic [2:0]          id,
    input int unsigned         sh
  );
    logic [DLX_WORD-1:0] ext;
    ext = {{(DLX_WORD-3){1'b0}}, id};
    return base + (ext << sh);
  endfunction

endpackage

// File: rtl/dlx_prio_enc.sv
// Lowest-index-first priority encoder.
// valid flags any request; index names the winning line.
module dlx_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/dlx_intr_ctrl.sv
// DLX interrupt controller: edge latch, ie flag, trap FSM
// and the vector driver onto dest_bus.
module dlx_intr_ctrl
  import dlx_pkg::*;
#(
  parameter int                  NUM_IRQ   = 4,
  parameter logic [DLX_WORD-1:0] VEC_BASE  = DEF_VEC_BASE,
  parameter int unsigned         VEC_SHIFT = DEF_VEC_SHIFT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                ie_set,
  input  logic                ie_clr,
  input  logic                intr_ack,
  input  logic                rfe,
  output logic                intr_req,
  output logic                pc_to_dest,
  output logic                IAR_load,
  output logic                pc_load,
  output logic [DLX_WORD-1:0] dest_bus,
  output logic [2:0]          irq_id,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  pending
);

  state_t               state;
  logic                 ie;
  logic [NUM_IRQ-1:0]   irq_prev;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   clr;
  logic [NUM_IRQ-1:0]   cand;
  logic                 cand_valid;
  logic [2:0]           cand_idx;
  logic [DLX_WORD-1:0]  vec;

  assign rise = irq & ~irq_prev;
  assign cand = pending & ~irq_mask;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (state == S_VECTOR) && (irq_id == 3'(i));
    end
  end

  dlx_prio_enc #(
    .N  (NUM_IRQ),
    .IW (3)
  ) u_prio (
    .req   (cand),
    .valid (cand_valid),
    .index (cand_idx)
  );

  // a fresh edge on the bit being cleared keeps it pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ie <= 1'b0;
    end else if (state == S_SAVE) begin
      ie <= 1'b0;
    end else if (state == S_INSVC && rfe) begin
      ie <= 1'b1;
    end else if (ie_clr) begin
      ie <= 1'b0;
    end else if (ie_set) begin
      ie <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      irq_id <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ie && cand_valid) begin
            state  <= S_REQ;
            irq_id <= cand_idx;
          end
        end
        S_REQ: begin
          if (intr_ack) state <= S_SAVE;
        end
        S_SAVE: state <= S_VECTOR;
        S_VECTOR: state <= S_INSVC;
        S_INSVC: begin
          if (rfe) begin
            state  <= S_IDLE;
            irq_id <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    intr_req   = 1'b0;
    pc_to_dest = 1'b0;
    IAR_load   = 1'b0;
    pc_load    = 1'b0;
    in_service = 1'b0;
    unique case (1'b1)
      state == S_REQ: intr_req = 1'b1;
      state == S_SAVE: begin
        pc_to_dest = 1'b1;
        IAR_load   = 1'b1;
      end
      state == S_VECTOR: pc_load = 1'b1;
      state == S_INSVC: in_service = 1'b1;
      default: ;
    endcase
  end

  assign vec      = vec_addr(VEC_BASE, irq_id, VEC_SHIFT);
  assign dest_bus = (state == S_VECTOR) ? vec : {DLX_WORD{1'bz}};

endmodule

// File: tb/tb_dlx_intr_ctrl.sv
// Scoreboarded bench for dlx_intr_ctrl: directed traps with
// expected vectors queued and checked when pc_load fires.
module tb_dlx_intr_ctrl;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] vec;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        ie_set;
  logic        ie_clr;
  logic        intr_ack;
  logic        rfe;
  logic        intr_req;
  logic        pc_to_dest;
  logic        IAR_load;
  logic        pc_load;
  wire  [31:0] dest_bus;
  logic [2:0]  irq_id;
  logic        in_service;
  logic [3:0]  pending;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  dlx_intr_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .irq        (irq),
    .irq_mask   (irq_mask),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .intr_ack   (intr_ack),
    .rfe        (rfe),
    .intr_req   (intr_req),
    .pc_to_dest (pc_to_dest),
    .IAR_load   (IAR_load),
    .pc_load    (pc_load),
    .dest_bus   (dest_bus),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every PC load must match the oldest queued trap
  always @(negedge clock) begin
    if (reset && pc_load) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pc_load got %h want none", dest_bus);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("vector", dest_bus, e.vec);
        chk("vec_irq_id", {29'b0, irq_id}, {29'b0, e.id});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq = lines;
    tick();
    irq = 4'b0;
  endtask

  // called with the FSM in REQ; leaves it in INSVC
  task automatic service(input logic [2:0] id, input logic [31:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    q.push_back(e);
    chk("req_id", {29'b0, irq_id}, {29'b0, id});
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    chk("save_strobes", {29'b0, intr_req, IAR_load, pc_to_dest}, 32'd3);
    tick();
    chk("vector_pc_load", {31'b0, pc_load}, 32'd1);
    tick();
    chk("insvc", {31'b0, in_service}, 32'd1);
  endtask

  task automatic do_rfe();
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    irq      = 4'b0;
    irq_mask = 4'b0;
    ie_set   = 1'b0;
    ie_clr   = 1'b0;
    intr_ack = 1'b0;
    rfe      = 1'b0;
    #1;
    chk("rst_strobes",
        {27'b0, intr_req, pc_to_dest, IAR_load, pc_load, in_service},
        32'd0);
    chk("rst_pending", {28'b0, pending}, 32'd0);
    chk("rst_irq_id", {29'b0, irq_id}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 1: single line, 2-cycle request latency
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    pulse(4'b0100);
    chk("t1_latched", {28'b0, pending}, 32'h4);
    chk("t1_no_req_yet", {31'b0, intr_req}, 32'd0);
    tick();
    chk("t1_req", {31'b0, intr_req}, 32'd1);
    service(3'd2, 32'h0000_0120);
    chk("t1_cleared", {28'b0, pending}, 32'h0);
    do_rfe();

    // 2: simultaneous lines, lowest index first
    pulse(4'b1010);
    tick();
    chk("t2_req", {31'b0, intr_req}, 32'd1);
    service(3'd1, 32'h0000_0110);
    chk("t2_pending", {28'b0, pending}, 32'h8);
    do_rfe();
    tick();
    chk("t2_req3", {31'b0, intr_req}, 32'd1);
    service(3'd3, 32'h0000_0130);
    do_rfe();

    // 3a: ie disabled holds the request off
    ie_clr = 1'b1;
    tick();
    ie_clr = 1'b0;
    pulse(4'b0001);
    tick();
    chk("t3_ie0_noreq", {31'b0, intr_req}, 32'd0);
    chk("t3_ie0_pend", {28'b0, pending}, 32'h1);
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    tick();
    chk("t3_ie_req", {31'b0, intr_req}, 32'd1);
    service(3'd0, 32'h0000_0100);
    do_rfe();

    // 3b: masked line latches but is not arbitrated
    irq_mask = 4'b0001;
    pulse(4'b0001);
    tick();
    tick();
    chk("t3_mask_noreq", {31'b0, intr_req}, 32'd0);
    chk("t3_mask_pend", {28'b0, pending}, 32'h1);
    irq_mask = 4'b0000;
    tick();
    chk("t3_unmask_req", {31'b0, intr_req}, 32'd1);
    service(3'd0, 32'h0000_0100);

    // 4: no nesting while in service, even after ie_set
    pulse(4'b0001);
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    tick();
    chk("t4_nest_noreq", {31'b0, intr_req}, 32'd0);
    chk("t4_nest_pend", {28'b0, pending}, 32'h1);
    do_rfe();
    chk("t4_idle", {31'b0, in_service}, 32'd0);
    tick();
    chk("t4_req", {31'b0, intr_req}, 32'd1);
    service(3'd0, 32'h0000_0100);
    do_rfe();

    // 5a: reset while requesting
    pulse(4'b0100);
    tick();
    chk("t5_req", {31'b0, intr_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_req_rst_strobes",
        {27'b0, intr_req, pc_to_dest, IAR_load, pc_load, in_service},
        32'd0);
    chk("t5_req_rst_pend", {28'b0, pending}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    pulse(4'b1000);
    tick();
    tick();
    chk("t5_ie_cleared", {31'b0, intr_req}, 32'd0);

    // 5b: reset during the vector cycle
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    tick();
    chk("t5b_req", {31'b0, intr_req}, 32'd1);
    chk("t5b_id", {29'b0, irq_id}, 32'd3);
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    tick();
    chk("t5b_in_vector", {31'b0, pc_load}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5b_rst_strobes",
        {27'b0, intr_req, pc_to_dest, IAR_load, pc_load, in_service},
        32'd0);
    chk("t5b_rst_pend", {28'b0, pending}, 32'h0);
    chk("t5b_rst_id", {29'b0, irq_id}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 6a: ie_clr beats ie_set
    ie_set = 1'b1;
    tick();
    ie_clr = 1'b1;
    tick();
    ie_set = 1'b0;
    ie_clr = 1'b0;
    pulse(4'b0010);
    tick();
    chk("t6_clr_wins", {31'b0, intr_req}, 32'd0);
    chk("t6_pend", {28'b0, pending}, 32'h2);
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    tick();
    chk("t6_req", {31'b0, intr_req}, 32'd1);

    // 6b: new edge on the bit cleared in VECTOR survives
    begin
      exp_t e;
      e.id  = 3'd1;
      e.vec = 32'h0000_0110;
      q.push_back(e);
    end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    tick();
    irq = 4'b0010;
    tick();
    irq = 4'b0000;
    chk("t6_set_wins", {28'b0, pending}, 32'h2);
    do_rfe();
    tick();
    chk("t6_rereq", {31'b0, intr_req}, 32'd1);
    service(3'd1, 32'h0000_0110);
    do_rfe();
    tick();
    tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
